serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing A - B one bit per clock, LSB first.
//   A START accepted in IDLE captures both operands. WIDTH SHIFT cycles follow.
//   FIN then presents the result for one cycle with DONE high.
//
// Handshake: START is a request that is taken only in IDLE, at a rising edge.
//   Requests made in any other state are dropped, and there is no ready signal.
//   DONE is a single-cycle completion pulse, and D/B_O/OVF are valid from it.
//   Those outputs hold until the next completion.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   RST_N      asynchronous active-low reset
//   START      request to begin a subtraction
//   A, B       minuend / subtrahend, sampled on the START-accepting edge
//   BUSY       high while bits are processed (WIDTH cycles)
//   DONE       one-cycle pulse; result outputs valid
//   D          A - B modulo 2^WIDTH
//   B_O        final borrow (A < B unsigned)
//   OVF        signed two's-complement overflow of A - B
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 FIN)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             B_O,
  output logic             OVF,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  // Cleared by reset and set on the first edge afterwards. A START present
  // on the edge right after an asynchronous release is therefore not taken.
  logic             armed;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Partial result. It holds the diff bits gathered so far and is filled
  // from the MSB end. The final bit completes the word directly into D.
  logic [WIDTH-2:0] d_sh;
  logic [WIDTH-1:0] d_full;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] bit_sel;
  logic             a_bit;
  logic             b_bit;
  logic             diff_bit;
  logic             brw_next;
  logic             last_bit;
  logic             accept;

  assign accept = (state == IDLE) && START && armed;

  // One full-subtractor step on the bit selected by the counter
  always_comb begin
    bit_sel  = WIDTH'(1) << cnt;
    a_bit    = |(a_reg & bit_sel);
    b_bit    = |(b_reg & bit_sel);
    diff_bit = a_bit ^ b_bit ^ brw;
    brw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw);
    d_full   = {diff_bit, d_sh};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        BUSY = 1'b1;
        if (last_bit) state_next = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      armed <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      B_O   <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        a_reg <= A;
        b_reg <= B;
        brw   <= 1'b0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        d_sh <= d_full[WIDTH-1:1];
        brw  <= brw_next;
        // Ends at WIDTH, which fits in CW bits, so the counter never wraps.
        cnt  <= cnt + CW'(1);
        if (last_bit) begin
          // Visible outputs change only here, on the edge that enters FIN.
          D   <= d_full;
          B_O <= brw_next;
          OVF <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (diff_bit ^ a_reg[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: WIDTH=8 and WIDTH=32 instances.
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start8, busy8, done8, bo8, ovf8;
  logic [7:0]  a8, b8, d8;
  logic [1:0]  st8;
  logic        start32, busy32, done32, bo32, ovf32;
  logic [31:0] a32, b32, d32;
  logic [1:0]  st32;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .D(d8), .B_O(bo8), .OVF(ovf8), .state_dbg(st8)
  );

  serial_subtractor #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST_N(rst_n), .START(start32), .A(a32), .B(b32),
    .BUSY(busy32), .DONE(done32), .D(d32), .B_O(bo32), .OVF(ovf32), .state_dbg(st32)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int n_done8 = 0, n_done32 = 0;
  int n_exp8 = 0, n_exp32 = 0;
  logic [31:0] hold_d[2];
  logic        hold_bo[2];
  logic        hold_ovf[2];

  always @(negedge clk) begin
    if (done8 === 1'b1) n_done8++;
    if (done32 === 1'b1) n_done32++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, borrow, d}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [32:0] diff;
    logic [31:0] mask, dd;
    logic am, bm;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    diff = {1'b0, a & mask} - {1'b0, b & mask};
    dd   = diff[31:0] & mask;
    am   = a[w-1];
    bm   = b[w-1];
    return {(am != bm) && (dd[w-1] != am), diff[32], dd};
  endfunction

  // {busy, done, bo, ovf, d}
  function automatic logic [35:0] sample(input int w);
    return (w == 8) ? {busy8, done8, bo8, ovf8, 24'd0, d8}
                    : {busy32, done32, bo32, ovf32, d32};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; a32 = a; b32 = b;
    end
  endtask

  // One operation. Inputs get scrambled every busy cycle. When repulse_at >= 0,
  // START is raised again in that busy cycle and must be ignored.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic ebo, input logic eovf,
                        input int repulse_at, input string tag);
    int idx, busy_n, done_i;
    logic stable;
    logic [35:0] s;
    idx = (w == 8) ? 0 : 1;
    busy_n = 0; done_i = -1; stable = 1'b1;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    for (int i = 0; i < 2 * w + 10 && done_i < 0; i++) begin
      @(negedge clk);
      drive(w, (i == repulse_at), $urandom, $urandom);
      s = sample(w);
      if (s[34]) done_i = i;
      else if (s[35]) begin
        busy_n++;
        if (s[31:0] !== hold_d[idx] || s[33] !== hold_bo[idx] || s[32] !== hold_ovf[idx])
          stable = 1'b0;
      end
    end
    check({tag, " latency"}, done_i, w);
    check({tag, " busy_cycles"}, busy_n, w);
    check({tag, " hold_during_shift"}, stable, 1);
    check({tag, " d"}, s[31:0], ed);
    check({tag, " b_o"}, s[33], ebo);
    check({tag, " ovf"}, s[32], eovf);
    hold_d[idx] = ed; hold_bo[idx] = ebo; hold_ovf[idx] = eovf;
    if (w == 8) n_exp8++; else n_exp32++;
    drive(w, 1'b0, 0, 0);
    @(negedge clk);
    s = sample(w);
    check({tag, " done_one_cycle"}, {s[35], s[34]}, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] a, b, d;
    logic       bo, ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k;
    logic [31:0] ra, rb;
    logic [33:0] r;
    int done_before;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    vecs[9] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};

    for (int i = 0; i < 2; i++) begin
      hold_d[i] = '0; hold_bo[i] = 1'b0; hold_ovf[i] = 1'b0;
    end

    // Reset with START already held high
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
    start32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs w8", {busy8, done8, bo8, ovf8, d8}, 0);
    check("reset outputs w32", {busy32, done32, bo32, ovf32} | d32, 0);
    check("reset state w8", st8, 0);

    // Release just before an edge: that edge ignores START, the next accepts
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("start ignored on release edge", busy8, 0);
    @(negedge clk);
    check("start accepted next edge", busy8, 1);
    k = 0;
    for (int j = 0; j < 30; j++) begin
      if (done8) break;
      @(negedge clk);
      k++;
    end
    check("post-reset latency", k, 8);
    check("post-reset d", d8, 8'h02);

    // START held high: next operation follows immediately after FIN
    k = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      k++;
      if (done8) break;
    end
    check("back-to-back done spacing", k, 10);
    check("back-to-back d", d8, 8'h02);
    n_exp8 += 2;
    start8 = 1'b0;
    @(negedge clk);
    check("idle after back-to-back", {busy8, done8}, 0);
    hold_d[0] = 32'h02; hold_bo[0] = 1'b0; hold_ovf[0] = 1'b0;

    // Table
    foreach (vecs[i])
      run_op(8, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ovf, -1, $sformatf("vec%0d", i));

    // START re-pulsed while busy: ignored, exactly one DONE
    done_before = n_done8;
    run_op(8, 32'h40, 32'h10, 32'h30, 1'b0, 1'b0, 3, "repulse");
    repeat (12) @(negedge clk);
    check("repulse done count", n_done8 - done_before, 1);

    // Reset in the 4th SHIFT cycle
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-shift busy before reset", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-shift reset outputs", {busy8, done8, bo8, ovf8, d8}, 0);
    check("mid-shift reset state", st8, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = '0; hold_bo[i] = 1'b0; hold_ovf[i] = 1'b0;
    end
    done_before = n_done8;
    repeat (20) @(negedge clk);
    check("no done after abandon", n_done8 - done_before, 0);
    run_op(8, 32'h10, 32'h01, 32'h0F, 1'b0, 1'b0, -1, "after reset");

    // WIDTH=32 directed
    run_op(32, 32'h5, 32'h3, 32'h2, 1'b0, 1'b0, -1, "w32 5-3");
    run_op(32, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1, 1'b0, -1, "w32 3-5");
    run_op(32, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, -1, "w32 min-1");
    run_op(32, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, -1, "w32 max+1");
    run_op(32, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5, "w32 repulse");

    // Random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      r = model(ra, rb, 8);
      run_op(8, ra, rb, r[31:0], r[32], r[33], -1, "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = (i % 16 == 0) ? ra : $urandom;
      r = model(ra, rb, 32);
      run_op(32, ra, rb, r[31:0], r[32], r[33], -1, "rand32");
    end

    repeat (3) @(negedge clk);
    check("done count w8", n_done8, n_exp8);
    check("done count w32", n_done32, n_exp32);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
